data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Multi-cycle data-memory slave that answers load/store requests from the processor's MEM stage.
- The MEM stage is the initiator; this block is the responder.
- Each request is accepted with a valid/ready handshake, held for a configurable number of wait states, then answered with a one-cycle response (read data or error).
- Drives a stall line so the pipeline registers hold while an access is outstanding.

Parameters:
- MEMORY_DEPTH, 256, number of 32-bit words stored.
- WAIT_STATES, 2, extra cycles between acceptance and response; legal range 0..15.
- BASE_ADDR, 32'h1001_0000, byte address of word 0 (data segment base).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  1  initiator presents a request.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data.
- req_ready_o  out  1  responder can accept a request this cycle.
- resp_valid_o  out  1  response present; single-cycle pulse, no backpressure.
- resp_rdata_o  out  32  load data; 0 for stores and errors.
- resp_err_o  out  1  misaligned or out-of-range access.
- stall_o  out  1  pipeline must hold its registers.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on rising clk.
- Reset drives the FSM to IDLE and clears all outputs and internal request latches to 0.
- Reset does not clear the memory array.
- A reset asserted mid-access drops the access: a store still in WAIT is not committed and no response is issued.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - req_ready_o = 1.
  - On a rising edge with req_valid_i=1, the block latches write, addr and wdata.
  - Next state is WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0, otherwise RESPOND.
- WAIT:
  - req_ready_o = 0.
  - The counter decrements each cycle.
  - When the counter is 0, the next state is RESPOND.
- Entering RESPOND, on the same edge:
  - A store commits: mem[idx] <= wdata, unless it is an error.
  - A load registers rdata from mem[idx].
  - resp_err_o is registered.
- RESPOND:
  - resp_valid_o = 1 for exactly one cycle; req_ready_o = 0.
  - Next state is IDLE unconditionally.
  - In every other state resp_valid_o, resp_rdata_o and resp_err_o are 0.
- Latency: request accepted at edge T gives resp_valid_o high during cycle T+1+WAIT_STATES.
  - Minimum back-to-back spacing is WAIT_STATES+2 cycles.
- stall_o = (IDLE & req_valid_i) | WAIT.
  - stall_o is 0 during RESPOND so the pipeline advances on the response cycle.
  - stall_o is combinational.
- Index: idx = (req_addr - BASE_ADDR) >> 2, 32-bit unsigned subtraction.
- Error when req_addr[1:0] != 0, or req_addr < BASE_ADDR, or idx >= MEMORY_DEPTH.
  - An error access has identical latency, writes nothing, returns rdata 0 and resp_err_o=1.
- Loads return 0 in resp_rdata_o when the access is an error.
- req_wdata_i and req_write_i are ignored outside acceptance cycles.
- Read-after-write on consecutive requests returns the new data.
- Only one access is outstanding at a time, so no read/write collision is possible.
- Inputs with req_valid_i=0 in IDLE cause no state change.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=2'd0, WAIT=2'd1, RESPOND=2'd2);
  - the wait-counter width, localparam CNT_W = 4;
  - BASE_ADDR default.
- One natural sub-module: mem_word_array.
  - Single-port synchronous word RAM, MEMORY_DEPTH x 32.
  - Ports: write enable, index, write data, registered read data.
  - No reset.
- The FSM, counter and address check stay in the top.

Test Plan:
- Store 32'hDEAD_BEEF to 0x1001_0008 with WAIT_STATES=2, then load 0x1001_0008 → store response at T+3 with err=0 and rdata=0; load response rdata = 32'hDEAD_BEEF. stall_o is high for exactly 3 cycles per access.
- Load 0x1001_0002 (misaligned) → resp_err_o=1 and rdata=0 at T+3. A subsequent load of 0x1001_0000 returns its previous contents unchanged.
- Store to 0x1001_0400 with MEMORY_DEPTH=256 (idx=256), and separately a load of 0x1000_FFFC (below base) → both give err=1 and memory is unchanged.
- Assert reset for one cycle during WAIT of a store of 32'h1234_5678 to 0x1001_0010 → no resp_valid_o, outputs 0, FSM in IDLE next cycle. A later load of that address returns the old value.
- WAIT_STATES=0, with req_valid_i held high continuously → responses every 2 cycles. req_ready_o toggles 1,0,1,0 and resp_valid_o pulses one cycle after each acceptance.
- Boundary: load idx 255 (0x1001_03FC) after a store there → correct data, err=0.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   state_t           - FSM state encoding (IDLE, WAIT, RESPOND)
//   CNT_W             - width of the wait-state counter (WAIT_STATES 0..15)
//   DEFAULT_BASE_ADDR - byte address of word 0 (data segment base)
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/data_memory_responder_mem_word_array.sv
// Single-port synchronous word RAM, MEMORY_DEPTH x 32. No reset.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable, writes wdata to mem[idx]
//   idx   - word index
//   wdata - write data
//   rdata - registered read data of mem[idx] (old contents on a write cycle)
module mem_word_array #(
  parameter  int unsigned MEMORY_DEPTH = 256,
  localparam int unsigned IDX_W        = $clog2(MEMORY_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// A request is accepted in IDLE, held for WAIT_STATES cycles, then answered
// with a single-cycle response carrying load data or an error flag.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   req_valid_i  - request present
//   req_write_i  - 1 = store, 0 = load
//   req_addr_i   - byte address
//   req_wdata_i  - store data
//   req_ready_o  - request can be accepted this cycle (IDLE)
//   resp_valid_o - one-cycle response pulse
//   resp_rdata_o - load data, 0 for stores and errors
//   resp_err_o   - misaligned or out-of-range access
//   stall_o      - pipeline hold, combinational
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter int unsigned WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o
);

  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             write_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic             resp_load_q;

  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] offset;
  logic [31:0] idx_full;
  logic        cur_err;
  logic        enter_resp;
  logic        ram_we;
  logic [31:0] ram_rdata;

  // With WAIT_STATES=0 the access completes on the acceptance edge, so the
  // live request inputs are used in IDLE and the latched copy afterwards.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_write = req_write_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
    end
  end

  always_comb begin
    offset   = cur_addr - BASE_ADDR;
    idx_full = offset >> 2;
    cur_err  = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE_ADDR) ||
               (idx_full >= 32'(MEMORY_DEPTH));
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state == IDLE) begin
      enter_resp = req_valid_i && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == '0);
    end
  end

  // Reset on the commit edge drops the store; the array itself has no reset.
  assign ram_we = enter_resp && cur_write && !cur_err && !reset;

  mem_word_array #(
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_full[IDX_W-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_load_q  <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_load_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state <= RESPOND;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESPOND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= cur_err;
        resp_load_q  <= !cur_write && !cur_err;
      end
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_load_q ? ram_rdata : '0;
  assign stall_o      = ((state == IDLE) && req_valid_i) || (state == WAIT);

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder.
// Instance a uses WAIT_STATES=2, instance b uses WAIT_STATES=0.
module tb_data_memory_responder;

  localparam int unsigned WS_A = 2;

  logic        clk;
  logic        rst_a, rst_b;
  logic        a_valid, a_write;
  logic [31:0] a_addr, a_wdata;
  logic        a_ready, a_resp_valid, a_err, a_stall;
  logic [31:0] a_rdata;
  logic        b_valid, b_write;
  logic [31:0] b_addr, b_wdata;
  logic        b_ready, b_resp_valid, b_err, b_stall;
  logic [31:0] b_rdata;

  int checks = 0;
  int errors = 0;

  data_memory_responder #(
    .MEMORY_DEPTH (256),
    .WAIT_STATES  (WS_A),
    .BASE_ADDR    (32'h1001_0000)
  ) u_a (
    .clk          (clk),
    .reset        (rst_a),
    .req_valid_i  (a_valid),
    .req_write_i  (a_write),
    .req_addr_i   (a_addr),
    .req_wdata_i  (a_wdata),
    .req_ready_o  (a_ready),
    .resp_valid_o (a_resp_valid),
    .resp_rdata_o (a_rdata),
    .resp_err_o   (a_err),
    .stall_o      (a_stall)
  );

  data_memory_responder #(
    .MEMORY_DEPTH (256),
    .WAIT_STATES  (0),
    .BASE_ADDR    (32'h1001_0000)
  ) u_b (
    .clk          (clk),
    .reset        (rst_b),
    .req_valid_i  (b_valid),
    .req_write_i  (b_write),
    .req_addr_i   (b_addr),
    .req_wdata_i  (b_wdata),
    .req_ready_o  (b_ready),
    .resp_valid_o (b_resp_valid),
    .resp_rdata_o (b_rdata),
    .resp_err_o   (b_err),
    .stall_o      (b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full access on instance a, checking every cycle from presentation to
  // the idle cycle after the response. Ends one cycle after the response.
  task automatic access_a(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err,
                          input logic [31:0] exp_rd);
    a_valid = 1'b1;
    a_write = wr;
    a_addr  = addr;
    a_wdata = wd;
    #1;
    chk({tag, " ready@0"}, a_ready, 1);
    chk({tag, " stall@0"}, a_stall, 1);
    next_cycle();
    a_valid = 1'b0;
    a_write = ~wr;
    a_addr  = 32'h0;
    a_wdata = 32'hFFFF_FFFF;
    for (int unsigned k = 1; k <= WS_A; k++) begin
      chk($sformatf("%s resp_valid@%0d", tag, k), a_resp_valid, 0);
      chk($sformatf("%s stall@%0d", tag, k), a_stall, 1);
      chk($sformatf("%s ready@%0d", tag, k), a_ready, 0);
      next_cycle();
    end
    chk({tag, " resp_valid"}, a_resp_valid, 1);
    chk({tag, " err"}, a_err, 32'(exp_err));
    chk({tag, " rdata"}, a_rdata, exp_rd);
    chk({tag, " stall@resp"}, a_stall, 0);
    chk({tag, " ready@resp"}, a_ready, 0);
    next_cycle();
    chk({tag, " resp_valid@idle"}, a_resp_valid, 0);
    chk({tag, " rdata@idle"}, a_rdata, 0);
    chk({tag, " err@idle"}, a_err, 0);
    chk({tag, " ready@idle"}, a_ready, 1);
    chk({tag, " stall@idle"}, a_stall, 0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    chk("reset ready", a_ready, 1);
    chk("reset resp_valid", a_resp_valid, 0);
    chk("reset rdata", a_rdata, 0);
    chk("reset err", a_err, 0);
    chk("reset stall", a_stall, 0);
    chk("reset b ready", b_ready, 1);
    chk("reset b resp_valid", b_resp_valid, 0);

    // Store then load-back
    access_a("st 08", 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 32'h0);
    access_a("ld 08", 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'hDEAD_BEEF);

    // Misaligned load leaves word 0 untouched
    access_a("st 00", 1'b1, 32'h1001_0000, 32'hA5A5_0001, 1'b0, 32'h0);
    access_a("ld mis", 1'b0, 32'h1001_0002, 32'h0,        1'b1, 32'h0);
    access_a("ld 00", 1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'hA5A5_0001);

    // Range boundaries: idx 255 valid, idx 256 and below-base are errors
    access_a("st 3fc", 1'b1, 32'h1001_03FC, 32'h1111_2222, 1'b0, 32'h0);
    access_a("st 400", 1'b1, 32'h1001_0400, 32'h0000_0BAD, 1'b1, 32'h0);
    access_a("ld below", 1'b0, 32'h1000_FFFC, 32'h0,       1'b1, 32'h0);
    access_a("ld 3fc", 1'b0, 32'h1001_03FC, 32'h0,         1'b0, 32'h1111_2222);
    access_a("ld 00 again", 1'b0, 32'h1001_0000, 32'h0,    1'b0, 32'hA5A5_0001);

    // Reset during WAIT drops a pending store
    access_a("st 10", 1'b1, 32'h1001_0010, 32'hCAFE_0010, 1'b0, 32'h0);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h1001_0010; a_wdata = 32'h1234_5678;
    #1;
    chk("rst ready@0", a_ready, 1);
    next_cycle();
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    chk("rst in wait", a_ready, 0);
    rst_a = 1'b1;
    next_cycle();
    rst_a = 1'b0;
    chk("rst resp_valid", a_resp_valid, 0);
    chk("rst ready idle", a_ready, 1);
    chk("rst stall", a_stall, 0);
    chk("rst rdata", a_rdata, 0);
    chk("rst err", a_err, 0);
    next_cycle();
    chk("rst resp_valid+1", a_resp_valid, 0);
    chk("rst ready+1", a_ready, 1);
    access_a("ld 10 old", 1'b0, 32'h1001_0010, 32'h0, 1'b0, 32'hCAFE_0010);

    // WAIT_STATES=0 with valid held high: responses every two cycles
    b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h1001_0020; b_wdata = 32'h0BAD_F00D;
    #1;
    chk("b c0 ready", b_ready, 1);
    chk("b c0 stall", b_stall, 1);
    next_cycle();
    b_write = 1'b0; b_wdata = 32'h5555_5555;
    #1;
    chk("b c1 resp_valid", b_resp_valid, 1);
    chk("b c1 err", b_err, 0);
    chk("b c1 rdata", b_rdata, 0);
    chk("b c1 ready", b_ready, 0);
    chk("b c1 stall", b_stall, 0);
    next_cycle();
    chk("b c2 ready", b_ready, 1);
    chk("b c2 resp_valid", b_resp_valid, 0);
    chk("b c2 stall", b_stall, 1);
    next_cycle();
    chk("b c3 resp_valid", b_resp_valid, 1);
    chk("b c3 rdata", b_rdata, 32'h0BAD_F00D);
    chk("b c3 err", b_err, 0);
    chk("b c3 ready", b_ready, 0);
    next_cycle();
    b_addr = 32'h1001_0021;
    #1;
    chk("b c4 ready", b_ready, 1);
    chk("b c4 resp_valid", b_resp_valid, 0);
    next_cycle();
    chk("b c5 resp_valid", b_resp_valid, 1);
    chk("b c5 err", b_err, 1);
    chk("b c5 rdata", b_rdata, 0);
    b_valid = 1'b0;
    next_cycle();
    chk("b c6 ready", b_ready, 1);
    chk("b c6 resp_valid", b_resp_valid, 0);
    chk("b c6 stall", b_stall, 0);
    next_cycle();
    chk("b c7 ready", b_ready, 1);
    chk("b c7 resp_valid", b_resp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
